// File: rtl/axi_line_read_arbiter.sv
// Shares one AXI read channel between I-cache and D-cache line fills.
// One burst in flight, round-robin grant, beats assembled into a full line.
//
// state | meaning
// IDLE  | waiting for a fill request; grant is combinational on req_valid
// ADDR  | AR presented for the granted requester until ar_ready
// DATA  | collecting R beats into the line buffer
// RESP  | line presented to the granted cache until resp_ready
module axi_line_read_arbiter #(
    parameter int unsigned BEATS = 4,
    parameter logic [3:0]  ID_I  = 4'h0,
    parameter logic [3:0]  ID_D  = 4'h1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_req_valid,
    output logic                i_req_ready,
    input  logic [31:0]         i_req_pc,
    output logic                i_resp_valid,
    input  logic                i_resp_ready,
    output logic [32*BEATS-1:0] i_resp_line,
    input  logic                d_req_valid,
    output logic                d_req_ready,
    input  logic [31:0]         d_req_addr,
    output logic                d_resp_valid,
    input  logic                d_resp_ready,
    output logic [32*BEATS-1:0] d_resp_data,
    output logic                ar_valid,
    output logic [3:0]          ar_id,
    output logic [31:0]         ar_address,
    output logic [3:0]          ar_length,
    output logic [2:0]          ar_size,
    output logic [1:0]          ar_burst,
    output logic [1:0]          ar_lock,
    output logic [3:0]          ar_cache,
    output logic [2:0]          ar_protect,
    input  logic                ar_ready,
    input  logic                r_valid,
    input  logic [3:0]          r_id,
    input  logic [31:0]         r_data,
    input  logic [1:0]          r_respond,
    input  logic                r_last,
    output logic                r_ready,
    output logic                rd_err
);
    localparam int unsigned CW = (BEATS > 1) ? $clog2(BEATS) : 1;

    typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

    state_t              state;
    logic                sel_i;
    logic                last_i;
    logic [31:0]         addr_q;
    logic [CW-1:0]       cnt;
    logic [32*BEATS-1:0] line_q;
    logic                err_q;

    logic                grant_i;
    logic                grant_d;
    logic [3:0]          gid;
    logic                beat_ok;
    logic                beat_end;
    logic                resp_hs;

    // last_i low after reset means D was granted last, so I wins the first tie
    always_comb begin
        grant_i = 1'b0;
        grant_d = 1'b0;
        if (state == IDLE) begin
            if (i_req_valid && (!d_req_valid || !last_i)) begin
                grant_i = 1'b1;
            end else if (d_req_valid) begin
                grant_d = 1'b1;
            end
        end
    end

    assign gid      = sel_i ? ID_I : ID_D;
    assign beat_ok  = (state == DATA) && r_valid && (r_id == gid);
    assign beat_end = beat_ok && (r_last || (cnt == CW'(BEATS - 1)));
    assign resp_hs  = (state == RESP) && (sel_i ? i_resp_ready : d_resp_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            sel_i  <= 1'b0;
            last_i <= 1'b0;
            addr_q <= '0;
            cnt    <= '0;
            line_q <= '0;
            err_q  <= 1'b0;
            rd_err <= 1'b0;
        end else begin
            rd_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_i || grant_d) begin
                        sel_i  <= grant_i;
                        last_i <= grant_i;
                        addr_q <= grant_i ? i_req_pc : d_req_addr;
                        state  <= ADDR;
                    end
                end
                ADDR: begin
                    if (ar_ready) begin
                        cnt   <= '0;
                        state <= DATA;
                    end
                end
                DATA: begin
                    if (beat_ok) begin
                        line_q[32*int'(cnt) +: 32] <= r_data;
                        cnt   <= (cnt == CW'(BEATS - 1)) ? '0 : cnt + 1'b1;
                        err_q <= err_q | (r_respond != 2'b00);
                        if (beat_end) begin
                            rd_err <= err_q | (r_respond != 2'b00);
                            state  <= RESP;
                        end
                    end
                end
                RESP: begin
                    if (resp_hs) begin
                        err_q <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign i_req_ready  = grant_i;
    assign d_req_ready  = grant_d;

    assign ar_valid     = (state == ADDR);
    assign ar_id        = gid;
    assign ar_address   = addr_q & ~32'hF;
    assign ar_length    = 4'(BEATS - 1);
    assign ar_size      = 3'b010;
    assign ar_burst     = 2'b01;
    assign ar_lock      = 2'b00;
    assign ar_cache     = 4'b0000;
    assign ar_protect   = 3'b000;

    assign r_ready      = (state == DATA);

    assign i_resp_valid = (state == RESP) && sel_i;
    assign d_resp_valid = (state == RESP) && !sel_i;
    assign i_resp_line  = line_q;
    assign d_resp_data  = line_q;
endmodule
